// File: rtl/uart_loader.sv
// uart_loader: serial program loader for the ARM16 RAM.
//   Receives 8N1 UART bytes on rx. The first two bytes are a little-endian
//   16-bit word count N. They are followed by N words, each sent low byte
//   first. The words are written to RAM from address 0 upward.
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   reset      synchronous, active-high reset
//   rx         asynchronous serial input; idles high
//   ram_addr   RAM write address (wraps modulo 2^ADDR_WIDTH)
//   ram_data   RAM write data
//   ram_we     RAM write strobe, one cycle per word
//   busy       high while a load is in progress; holds off core fetch
//   done       one-cycle pulse when a load completes
//   frame_err  sticky flag; set when a stop bit is sampled low
module uart_loader #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_data,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_C  = CW'(DIV);
    localparam logic [CW-1:0] HALF_C = CW'(DIV / 2);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_e;
    typedef enum logic [2:0] {L_LEN_LO, L_LEN_HI, L_DAT_LO, L_DAT_HI, L_WR} l_state_e;

    // ---------------- synchronizer ----------------
    logic rx_m_q, rx_s_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
        end
    end

    // ---------------- receiver ----------------
    r_state_e       r_state_q, r_state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           ferr_q, ferr_d;
    logic           byte_valid, byte_err;
    logic           expire;

    // The counter is loaded with the number of cycles to wait; the sample
    // is taken in the cycle where it reads 1.
    assign expire = (cnt_q == CW'(1));

    always_comb begin
        r_state_d  = r_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        if (r_state_q != R_IDLE && !expire) cnt_d = cnt_q - CW'(1);
        case (r_state_q)
            R_IDLE: if (!rx_s_q) begin
                r_state_d = R_START;
                cnt_d     = HALF_C;
            end
            R_START: if (expire) begin
                if (rx_s_q) begin
                    r_state_d = R_IDLE;      // glitch, not a real start bit
                end else begin
                    r_state_d = R_DATA;
                    cnt_d     = DIV_C;
                    bit_d     = 3'd0;
                end
            end
            R_DATA: if (expire) begin
                shreg_d = {rx_s_q, shreg_q[7:1]};
                cnt_d   = DIV_C;
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) r_state_d = R_STOP;
            end
            R_STOP: if (expire) begin
                byte_valid = rx_s_q;
                byte_err   = !rx_s_q;
                r_state_d  = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        ferr_d = ferr_q | byte_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            ferr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            ferr_q    <= ferr_d;
        end
    end

    // ---------------- loader ----------------
    l_state_e              l_state_q, l_state_d;
    logic [7:0]            len_lo_q, len_lo_d, lo_q, lo_d;
    logic [15:0]           rem_q, rem_d, data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        l_state_d = l_state_q;
        len_lo_d  = len_lo_q;
        lo_d      = lo_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (byte_err) begin
            // Bad frame: drop the load; words already written stay in RAM.
            l_state_d = L_LEN_LO;
            busy_d    = 1'b0;
        end else begin
            case (l_state_q)
                L_LEN_LO: if (byte_valid) begin
                    len_lo_d  = shreg_q;
                    l_state_d = L_LEN_HI;
                end
                L_LEN_HI: if (byte_valid) begin
                    if ({shreg_q, len_lo_q} == 16'd0) begin
                        done_d    = 1'b1;
                        l_state_d = L_LEN_LO;
                    end else begin
                        rem_d     = {shreg_q, len_lo_q};
                        addr_d    = '0;
                        busy_d    = 1'b1;
                        l_state_d = L_DAT_LO;
                    end
                end
                L_DAT_LO: if (byte_valid) begin
                    lo_d      = shreg_q;
                    l_state_d = L_DAT_HI;
                end
                L_DAT_HI: if (byte_valid) begin
                    we_d      = 1'b1;
                    data_d    = {shreg_q, lo_q};
                    l_state_d = L_WR;
                end
                // Write cycle: ram_we is high now; advance on the edge
                // where it falls, so done never overlaps ram_we.
                L_WR: begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        l_state_d = L_LEN_LO;
                    end else begin
                        l_state_d = L_DAT_LO;
                    end
                end
                default: l_state_d = L_LEN_LO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l_state_q <= L_LEN_LO;
            len_lo_q  <= '0;
            lo_q      <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            l_state_q <= l_state_d;
            len_lo_q  <= len_lo_d;
            lo_q      <= lo_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_data  = data_q;
    assign ram_we    = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1, rx2 = 1'b1;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data;
    logic        ram_we, busy, done, frame_err;
    logic [1:0]  ram_addr2;
    logic [15:0] ram_data2;
    logic        ram_we2, busy2, done2, frame_err2;

    always #5 clk = ~clk;

    uart_loader #(.CLK_HZ(1000000), .BAUD(100000), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .busy(busy), .done(done), .frame_err(frame_err));

    uart_loader #(.CLK_HZ(1000000), .BAUD(100000), .ADDR_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .rx(rx2),
        .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_we(ram_we2),
        .busy(busy2), .done(done2), .frame_err(frame_err2));

    typedef struct packed {
        logic        dn;     // 1: done pulse expected, 0: RAM write expected
        logic [7:0]  a;
        logic [15:0] d;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic exp_t wr(input logic [7:0] a, input logic [15:0] d);
        wr = '{dn: 1'b0, a: a, d: d};
    endfunction
    function automatic exp_t dn();
        dn = '{dn: 1'b1, a: 8'h0, d: 16'h0};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (ram_we && done) begin
            vectors++; miscompares++;
            $display("FAIL we_done_overlap dut0 at %0t", $time);
        end
        if (ram_we) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write dut0 addr=%0h data=%0h", ram_addr, ram_data);
            end else begin
                e = q.pop_front();
                if (e.dn || e.a != ram_addr || e.d != ram_data) begin
                    miscompares++;
                    $display("FAIL write dut0 got addr=%0h data=%0h, want dn=%0b addr=%0h data=%0h",
                             ram_addr, ram_data, e.dn, e.a, e.d);
                end
            end
        end
        if (done) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done dut0 at %0t", $time);
            end else begin
                e = q.pop_front();
                if (!e.dn) begin
                    miscompares++;
                    $display("FAIL done dut0 got done, want write addr=%0h data=%0h", e.a, e.d);
                end
            end
        end
        if (ram_we2 && done2) begin
            vectors++; miscompares++;
            $display("FAIL we_done_overlap dut2 at %0t", $time);
        end
        if (ram_we2) begin
            vectors++;
            if (q2.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write dut2 addr=%0h data=%0h", ram_addr2, ram_data2);
            end else begin
                e = q2.pop_front();
                if (e.dn || e.a[1:0] != ram_addr2 || e.d != ram_data2) begin
                    miscompares++;
                    $display("FAIL write dut2 got addr=%0h data=%0h, want dn=%0b addr=%0h data=%0h",
                             ram_addr2, ram_data2, e.dn, e.a[1:0], e.d);
                end
            end
        end
        if (done2) begin
            vectors++;
            if (q2.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done dut2 at %0t", $time);
            end else begin
                e = q2.pop_front();
                if (!e.dn) begin
                    miscompares++;
                    $display("FAIL done dut2 got done, want write addr=%0h data=%0h", e.a, e.d);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit which, input logic v);
        if (which) rx2 = v;
        else       rx  = v;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1, input bit which = 1'b0);
        drv(which, 1'b0);
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            drv(which, b[i]);
            repeat (DIV) tick();
        end
        drv(which, stop_v);
        repeat (DIV) tick();
        drv(which, 1'b1);
        repeat (4) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_data", 32'(ram_data), 0);
        chk("rst_we_busy_done_ferr", {28'b0, ram_we, busy, done, frame_err}, 0);
        reset = 1'b0;
        repeat (5) tick();

        // 1: two-word load
        q.push_back(wr(8'd0, 16'h1234));
        q.push_back(wr(8'd1, 16'hABCD));
        q.push_back(dn());
        send_byte(8'h02);
        chk("s1_busy_idle", 32'(busy), 0);
        send_byte(8'h00);
        chk("s1_busy_loading", 32'(busy), 1);
        send_byte(8'h34);
        send_byte(8'h12);
        chk("s1_busy_mid", 32'(busy), 1);
        send_byte(8'hCD);
        send_byte(8'hAB);
        chk("s1_busy_end", 32'(busy), 0);
        chk("s1_ferr", 32'(frame_err), 0);
        chk("s1_hold_addr", 32'(ram_addr), 2);
        chk("s1_hold_data", 32'(ram_data), 32'hABCD);

        // 2: zero-length load
        q.push_back(dn());
        send_byte(8'h00);
        send_byte(8'h00);
        chk("s2_busy", 32'(busy), 0);

        // 3: start-bit glitch, then a valid one-word load
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (20) tick();
        chk("s3_busy_glitch", 32'(busy), 0);
        q.push_back(wr(8'd0, 16'hBEEF));
        q.push_back(dn());
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hEF);
        send_byte(8'hBE);

        // 4: framing error mid-load, then a normal load
        q.push_back(wr(8'd0, 16'h1111));
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h11);
        send_byte(8'h55, 1'b0);
        repeat (10) tick();
        chk("s4_ferr_set", 32'(frame_err), 1);
        chk("s4_busy_drop", 32'(busy), 0);
        q.push_back(wr(8'd0, 16'h2222));
        q.push_back(dn());
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h22);
        send_byte(8'h22);
        chk("s4_ferr_sticky", 32'(frame_err), 1);

        // 5: ADDR_WIDTH=2 wrap on the second instance
        for (int i = 1; i <= 5; i++) q2.push_back(wr(8'((i - 1) % 4), 16'(i)));
        q2.push_back(dn());
        send_byte(8'h05, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, 1'b1);
            send_byte(8'h00, 1'b1, 1'b1);
        end
        chk("s5_addr_wrapped", 32'(ram_addr2), 1);
        chk("s5_busy", 32'(busy2), 0);

        // 6: reset during 2nd data bit of 4th byte of a 2-word load
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        rx = 1'b0;                  // start bit of 0x22
        repeat (DIV) tick();
        rx = 1'b0;                  // bit0
        repeat (DIV) tick();
        rx = 1'b1;                  // bit1
        repeat (5) tick();
        chk("s6_busy_before", 32'(busy), 1);
        reset = 1'b1;
        tick();
        chk("s6_rst_addr", 32'(ram_addr), 0);
        chk("s6_rst_data", 32'(ram_data), 0);
        chk("s6_rst_flags", {28'b0, ram_we, busy, done, frame_err}, 0);
        reset = 1'b0;
        rx = 1'b1;
        repeat (30) tick();
        q.push_back(wr(8'd0, 16'h55AA));
        q.push_back(dn());
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'h55);

        repeat (20) tick();
        chk("q0_drained", 32'(q.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
